// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for the PicoRV32-native memory bus, with a
// slave-response watchdog that completes unanswered transactions.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT       = 64,
  parameter logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF,
  parameter int unsigned CNT_W         = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic [1:0]  grant,
  output logic        timeout_flag,
  output logic [31:0] timeout_addr,
  input  logic        timeout_clr
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [1:0]       grant_nxt;
  logic             last_owner, last_owner_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             busy, owner, to_hit, done, pick1;
  logic [31:0]      rsp;

  assign busy   = (state == BUSY);
  assign owner  = grant[1];
  // s_ready in the final watchdog cycle wins over the timeout
  assign to_hit = (TIMEOUT != 0) && busy && !s_ready && (cnt == CNT_LAST);
  assign done   = busy && (s_ready || to_hit);
  // m1 wins when alone, or on contention when m0 owned the bus last
  assign pick1  = m1_valid && (!m0_valid || !last_owner);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= 2'b00;
      last_owner <= 1'b1;
      cnt        <= '0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_owner <= last_owner_nxt;
      cnt        <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_owner_nxt = last_owner;
    cnt_nxt        = cnt;
    case (state)
      IDLE: begin
        if (m0_valid || m1_valid) begin
          state_nxt = BUSY;
          grant_nxt = pick1 ? 2'b10 : 2'b01;
          cnt_nxt   = '0;
        end
      end
      BUSY: begin
        if (done) begin
          state_nxt      = IDLE;
          grant_nxt      = 2'b00;
          last_owner_nxt = owner;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_flag <= 1'b0;
      timeout_addr <= '0;
    end else if (to_hit) begin
      timeout_flag <= 1'b1;
      timeout_addr <= s_addr;
    end else if (timeout_clr) begin
      timeout_flag <= 1'b0;
    end
  end

  // Idle bus parks on m0's address/data with strobes forced to read
  assign s_valid = busy;
  assign s_addr  = (busy && owner) ? m1_addr  : m0_addr;
  assign s_wdata = (busy && owner) ? m1_wdata : m0_wdata;
  assign s_wstrb = busy ? (owner ? m1_wstrb : m0_wstrb) : 4'b0000;

  assign rsp      = s_ready ? s_rdata : TIMEOUT_RDATA;
  assign m0_ready = done && !owner;
  assign m1_ready = done && owner;
  assign m0_rdata = m0_ready ? rsp : '0;
  assign m1_rdata = m1_ready ? rsp : '0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized + directed bench for mem_bus_arbiter against a transaction-level
// reference model; a second instance covers the disabled-watchdog case.
module tb_mem_bus_arbiter;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mv;
  logic [31:0] ma [2];
  logic [31:0] mw [2];
  logic [3:0]  ms [2];
  logic [1:0]  mr;
  logic [31:0] mrd [2];
  logic        s_valid, s_ready, timeout_flag, timeout_clr;
  logic [31:0] s_addr, s_wdata, s_rdata, timeout_addr;
  logic [3:0]  s_wstrb;
  logic [1:0]  grant;

  // watchdog-disabled instance
  logic        n_valid, n_rdy, n_svalid, n_sready, n_flag, n_rdy1, z1;
  logic [31:0] n_addr, n_rdata, n_saddr, n_swdata, n_srdata, n_taddr, n_rdata1, z32;
  logic [3:0]  n_swstrb, z4;
  logic [1:0]  n_grant;

  int n_chk = 0, n_fail = 0;

  // reference model: owner index (-1 idle), who was served last, stall cycles
  int          own, prev, waited;
  logic        mflag;
  logic [31:0] mfaddr, last_rd0;
  bit          exp_rdy [2];
  bit          hold_req, rnd;
  logic [1:0]  gprev;
  logic [1:0]  gq [$];

  always #5 clk = ~clk;

  mem_bus_arbiter #(.TIMEOUT(TMO), .TIMEOUT_RDATA(32'hDEAD_BEEF), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .m0_valid(mv[0]), .m0_addr(ma[0]), .m0_wdata(mw[0]), .m0_wstrb(ms[0]),
    .m0_ready(mr[0]), .m0_rdata(mrd[0]),
    .m1_valid(mv[1]), .m1_addr(ma[1]), .m1_wdata(mw[1]), .m1_wstrb(ms[1]),
    .m1_ready(mr[1]), .m1_rdata(mrd[1]),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .grant(grant), .timeout_flag(timeout_flag), .timeout_addr(timeout_addr),
    .timeout_clr(timeout_clr)
  );

  mem_bus_arbiter #(.TIMEOUT(0), .TIMEOUT_RDATA(32'hDEAD_BEEF), .CNT_W(8)) dut_nt (
    .clk(clk), .rst(rst),
    .m0_valid(n_valid), .m0_addr(n_addr), .m0_wdata(z32), .m0_wstrb(z4),
    .m0_ready(n_rdy), .m0_rdata(n_rdata),
    .m1_valid(z1), .m1_addr(z32), .m1_wdata(z32), .m1_wstrb(z4),
    .m1_ready(n_rdy1), .m1_rdata(n_rdata1),
    .s_valid(n_svalid), .s_addr(n_saddr), .s_wdata(n_swdata), .s_wstrb(n_swstrb),
    .s_ready(n_sready), .s_rdata(n_srdata),
    .grant(n_grant), .timeout_flag(n_flag), .timeout_addr(n_taddr),
    .timeout_clr(z1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    own = -1; prev = 1; waited = 0; mflag = 1'b0; mfaddr = '0;
    exp_rdy[0] = 0; exp_rdy[1] = 0;
  endtask

  // Called at posedge+1 with inputs set; checks at the negedge, advances the model.
  task automatic cycle();
    bit fin, tmo;
    logic [31:0] eg;
    #4;
    fin = 0; tmo = 0;
    eg = (own < 0) ? 32'd0 : ((own == 0) ? 32'd1 : 32'd2);
    chk("grant", 32'(grant), eg);
    chk("s_valid", 32'(s_valid), 32'(own >= 0));
    if (own >= 0) begin
      chk("s_addr", s_addr, ma[own]);
      chk("s_wdata", s_wdata, mw[own]);
      chk("s_wstrb", 32'(s_wstrb), 32'(ms[own]));
      tmo = !s_ready && (waited == TMO - 1);
      fin = s_ready || tmo;
    end else begin
      chk("idle_addr", s_addr, ma[0]);
      chk("idle_wdata", s_wdata, mw[0]);
      chk("idle_wstrb", 32'(s_wstrb), 32'd0);
    end
    for (int i = 0; i < 2; i++) begin
      exp_rdy[i] = fin && (own == i);
      chk($sformatf("m%0d_ready", i), 32'(mr[i]), 32'(exp_rdy[i]));
      if (exp_rdy[i]) chk($sformatf("m%0d_rdata", i), mrd[i], s_ready ? s_rdata : 32'hDEAD_BEEF);
      else if (own != i) chk($sformatf("m%0d_rdata_idle", i), mrd[i], 32'd0);
    end
    chk("timeout_flag", 32'(timeout_flag), 32'(mflag));
    chk("timeout_addr", timeout_addr, mfaddr);
    if (mr[0]) last_rd0 = mrd[0];
    if (grant != 2'b00 && gprev == 2'b00) gq.push_back(grant);
    gprev = grant;
    if (own < 0) begin
      if (mv[0] && mv[1]) own = (prev == 0) ? 1 : 0;
      else if (mv[0])     own = 0;
      else if (mv[1])     own = 1;
      waited = 0;
    end else if (fin) begin
      if (tmo) begin mflag = 1'b1; mfaddr = ma[own]; end
      prev = own;
      own  = -1;
    end else begin
      waited++;
    end
    if (timeout_clr && !tmo) mflag = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      cycle();
      for (int i = 0; i < 2; i++) begin
        if (exp_rdy[i] && !hold_req) mv[i] = 1'b0;
        if (rnd && !mv[i] && ($urandom % 4 == 0)) begin
          mv[i] = 1'b1; ma[i] = $urandom; mw[i] = $urandom; ms[i] = 4'($urandom);
        end
      end
      if (rnd) begin
        s_ready     = ($urandom % 3 == 0);
        s_rdata     = $urandom;
        timeout_clr = ($urandom % 16 == 0);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL bench_timeout: simulation did not finish, n_fail %0d", n_fail);
    $fatal(1, "bench time limit");
  end

  initial begin
    rst = 1'b1; mv = 2'b00; hold_req = 0; rnd = 0; gprev = 2'b00; last_rd0 = '0;
    for (int i = 0; i < 2; i++) begin ma[i] = '0; mw[i] = '0; ms[i] = '0; end
    s_ready = 1'b0; s_rdata = '0; timeout_clr = 1'b0;
    n_valid = 1'b0; n_addr = '0; n_sready = 1'b0; n_srdata = '0;
    z1 = 1'b0; z4 = '0; z32 = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    run(2);

    // single master, zero-wait slave
    mv[0] = 1'b1; ma[0] = 32'h0000_0010; mw[0] = 32'h0; ms[0] = 4'h0;
    s_ready = 1'b1; s_rdata = 32'h1234_5678;
    run(4);
    chk("single_rdata", last_rd0, 32'h1234_5678);

    // async reset in the middle of a stalled m1 transaction
    s_ready = 1'b0;
    mv[1] = 1'b1; ma[1] = 32'h0000_2000; mw[1] = 32'h0; ms[1] = 4'h0;
    run(3);
    rst = 1'b1;
    #1;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_s_valid", 32'(s_valid), 32'd0);
    chk("rst_m0_ready", 32'(mr[0]), 32'd0);
    chk("rst_m1_ready", 32'(mr[1]), 32'd0);
    mv = 2'b00;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    run(1);

    // contention with both masters requesting continuously
    gq.delete();
    hold_req = 1; s_ready = 1'b1; s_rdata = 32'h0BAD_F00D;
    ma[0] = 32'h0000_0100; ma[1] = 32'h0000_0200; mv = 2'b11;
    run(8);
    hold_req = 0; mv = 2'b00;
    run(2);
    chk("rr_count", 32'(gq.size()), 32'd4);
    for (int k = 0; k < 4 && k < gq.size(); k++)
      chk($sformatf("rr_seq%0d", k), 32'(gq[k]), (k % 2 == 0) ? 32'd1 : 32'd2);

    // m1 write muxing, m0 payload parked but not requesting
    ma[0] = 32'hFFFF_0000; mw[0] = 32'h1111_1111; ms[0] = 4'hF;
    mv[1] = 1'b1; ma[1] = 32'h0020_0004; mw[1] = 32'hA5A5_0001; ms[1] = 4'b0011;
    s_ready = 1'b0;
    run(3);
    s_ready = 1'b1;
    run(2);
    ms[0] = 4'h0;

    // watchdog timeout, then clear
    s_ready = 1'b0;
    mv[0] = 1'b1; ma[0] = 32'h0F00_0000;
    run(11);
    chk("to_rdata", last_rd0, 32'hDEAD_BEEF);
    chk("to_flag", 32'(timeout_flag), 32'd1);
    chk("to_addr", timeout_addr, 32'h0F00_0000);
    timeout_clr = 1'b1;
    run(1);
    timeout_clr = 1'b0;
    chk("to_clr", 32'(timeout_flag), 32'd0);

    // clear held through a second timeout: set wins
    timeout_clr = 1'b1;
    mv[0] = 1'b1; ma[0] = 32'h0F00_0040;
    run(9);
    timeout_clr = 1'b0;
    chk("to_set_wins", 32'(timeout_flag), 32'd1);
    chk("to_addr2", timeout_addr, 32'h0F00_0040);

    // s_ready on the final watchdog cycle completes normally
    timeout_clr = 1'b1;
    run(1);
    timeout_clr = 1'b0;
    mv[0] = 1'b1; ma[0] = 32'h0F00_0080;
    run(1);
    run(TMO - 1);
    s_ready = 1'b1; s_rdata = 32'h600D_CAFE;
    run(1);
    s_ready = 1'b0;
    run(1);
    chk("bnd_rdata", last_rd0, 32'h600D_CAFE);
    chk("bnd_flag", 32'(timeout_flag), 32'd0);

    // randomized traffic
    rnd = 1;
    run(3000);
    rnd = 0; s_ready = 1'b1; timeout_clr = 1'b0;
    for (int k = 0; k < 50 && (own >= 0 || mv != 2'b00); k++) run(1);
    chk("drain", 32'(own >= 0 || mv != 2'b00), 32'd0);

    // watchdog disabled: long stall must not time out
    n_valid = 1'b1; n_addr = 32'h0F00_1000;
    begin
      int seen = 0;
      repeat (300) begin
        @(negedge clk);
        if (n_rdy) seen++;
      end
      chk("nt_no_ready", 32'(seen), 32'd0);
    end
    chk("nt_svalid", 32'(n_svalid), 32'd1);
    chk("nt_flag_stall", 32'(n_flag), 32'd0);
    @(posedge clk); #1;
    n_sready = 1'b1; n_srdata = 32'hCAFE_0300;
    @(negedge clk);
    chk("nt_ready", 32'(n_rdy), 32'd1);
    chk("nt_rdata", n_rdata, 32'hCAFE_0300);
    @(posedge clk); #1;
    n_valid = 1'b0; n_sready = 1'b0;
    @(negedge clk);
    chk("nt_flag", 32'(n_flag), 32'd0);
    chk("nt_grant_idle", 32'(n_grant), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
